// File: rtl/spw_link_pkg.sv
// Shared definitions for the SpaceWire link-start controller: controller
// state codes, the link interface FSM state encoding and status-word layout.
package spw_link_pkg;

    // Controller state; the numeric codes are visible to software in status[2:0].
    typedef enum logic [2:0] {
        CTRL_IDLE     = 3'd0,
        CTRL_ARM      = 3'd1,
        CTRL_WAIT_RUN = 3'd2,
        CTRL_RUN      = 3'd3,
        CTRL_BACKOFF  = 3'd4,
        CTRL_FAIL     = 3'd5
    } ctrl_state_e;

    // Link interface FSM state encoding; codes 6 and 7 behave like ErrorReset.
    localparam logic [2:0] LS_ERROR_RESET = 3'd0;
    localparam logic [2:0] LS_ERROR_WAIT  = 3'd1;
    localparam logic [2:0] LS_READY       = 3'd2;
    localparam logic [2:0] LS_STARTED     = 3'd3;
    localparam logic [2:0] LS_CONNECTING  = 3'd4;
    localparam logic [2:0] LS_RUN         = 3'd5;

    // Status word bit positions.
    localparam int ST_CODE_LSB  = 0;
    localparam int ST_CODE_MSB  = 2;
    localparam int ST_LINK_UP   = 3;
    localparam int ST_LINK_FAIL = 4;

    // Only the Run state counts as a live link; everything else is "not up".
    function automatic logic is_link_run(input logic [2:0] ls);
        return ls == LS_RUN;
    endfunction

endpackage

// File: rtl/spw_sync_bit.sv
// Single-bit multi-flop synchronizer for a level coming from another clock
// domain. All stages reset to 0 so an asserted command is seen only after
// SYNC_STAGES clock edges following reset release.
module spw_sync_bit #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] stage_reg;

    // Shift the asynchronous level through the synchronizer chain.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stage_reg <= '0;
        end else begin
            stage_reg <= {stage_reg[SYNC_STAGES-2:0], d};
        end
    end

    assign q = stage_reg[SYNC_STAGES-1];

endmodule

// File: rtl/spw_link_start_ctrl.sv
// Link-start supervisor between the PIO command bits and the SpaceWire link
// interface FSM. Turns command levels into link FSM controls, supervises each
// connection attempt with a timeout, spaces attempts with a backoff period and
// gives up after a bounded number of failures. All outputs are registered and
// reflect the state the controller is in (timer and link_start are set on
// entry to ARM/BACKOFF, so link_start is high for exactly TIMEOUT_CYCLES per
// attempt and low for exactly BACKOFF_CYCLES between attempts).
module spw_link_start_ctrl
    import spw_link_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int CNT_W          = 16,
    parameter int TIMEOUT_CYCLES = 5000,
    parameter int BACKOFF_CYCLES = 2500,
    parameter int MAX_RETRY      = 15
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start_req,
    input  logic       auto_req,
    input  logic       disable_req,
    input  logic [2:0] link_state,
    output logic       link_start,
    output logic       auto_start,
    output logic       link_disable,
    output logic       link_up,
    output logic       link_fail,
    output logic [3:0] retry_count,
    output logic [7:0] status
);

    // ------------------------------------------------------------------
    // Configuration sanity checks (elaboration time)
    // ------------------------------------------------------------------
    if (SYNC_STAGES < 2) begin : g_bad_sync_stages
        $error("spw_link_start_ctrl: SYNC_STAGES must be at least 2");
    end
    if ((TIMEOUT_CYCLES < 1) || (longint'(TIMEOUT_CYCLES) > (longint'(1) << CNT_W))) begin : g_bad_timeout
        $error("spw_link_start_ctrl: TIMEOUT_CYCLES must be in 1..2**CNT_W");
    end
    if ((BACKOFF_CYCLES < 1) || (longint'(BACKOFF_CYCLES) > (longint'(1) << CNT_W))) begin : g_bad_backoff
        $error("spw_link_start_ctrl: BACKOFF_CYCLES must be in 1..2**CNT_W");
    end
    if ((MAX_RETRY < 0) || (MAX_RETRY > 15)) begin : g_bad_max_retry
        $error("spw_link_start_ctrl: MAX_RETRY must fit in 4 bits");
    end

    localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] BACKOFF_LOAD = CNT_W'(BACKOFF_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMER_ONE    = CNT_W'(1);
    localparam logic [3:0]       RETRY_LIMIT  = 4'(MAX_RETRY);

    // ------------------------------------------------------------------
    // Command synchronizers: bit 0 start, bit 1 auto, bit 2 disable
    // ------------------------------------------------------------------
    logic [2:0] req_async;
    logic [2:0] req_sync;
    logic       start_s;
    logic       auto_s;
    logic       disable_s;

    assign req_async = {disable_req, auto_req, start_req};

    for (genvar gi = 0; gi < 3; gi++) begin : g_sync
        spw_sync_bit #(
            .SYNC_STAGES(SYNC_STAGES)
        ) u_sync (
            .clk    (clk),
            .reset_n(reset_n),
            .d      (req_async[gi]),
            .q      (req_sync[gi])
        );
    end

    assign start_s   = req_sync[0];
    assign auto_s    = req_sync[1];
    assign disable_s = req_sync[2];

    // ------------------------------------------------------------------
    // Controller state
    // ------------------------------------------------------------------
    ctrl_state_e      state_reg;
    ctrl_state_e      state_next;
    logic [CNT_W-1:0] timer_reg;
    logic [CNT_W-1:0] timer_next;
    logic [CNT_W-1:0] timer_dec;
    logic [3:0]       retry_reg;
    logic [3:0]       retry_next;
    logic [3:0]       retry_inc;
    logic             link_is_run;

    // Timer floors at zero; retry counter saturates at the configured limit.
    assign timer_dec   = (timer_reg == '0) ? '0 : (timer_reg - TIMER_ONE);
    assign retry_inc   = (retry_reg >= RETRY_LIMIT) ? retry_reg : (retry_reg + 4'd1);
    assign link_is_run = is_link_run(link_state);

    // Next-state, timer and retry decisions; disable overrides every state.
    always_comb begin
        state_next = state_reg;
        timer_next = timer_reg;
        retry_next = retry_reg;
        if (disable_s) begin
            state_next = CTRL_IDLE;
            timer_next = '0;
            retry_next = '0;
        end else begin
            case (state_reg)
                CTRL_IDLE: begin
                    if (start_s) begin
                        state_next = CTRL_ARM;
                        timer_next = TIMEOUT_LOAD;
                        retry_next = '0;
                    end
                end
                CTRL_ARM: begin
                    // The attempt window already started counting on ARM entry.
                    state_next = CTRL_WAIT_RUN;
                    timer_next = timer_dec;
                end
                CTRL_WAIT_RUN: begin
                    timer_next = timer_dec;
                    if (!start_s) begin
                        state_next = CTRL_IDLE;
                        timer_next = '0;
                    end else if (link_is_run) begin
                        // A link reaching Run on the timeout cycle still counts as connected.
                        state_next = CTRL_RUN;
                    end else if (timer_reg == '0) begin
                        state_next = CTRL_BACKOFF;
                        timer_next = BACKOFF_LOAD;
                        retry_next = retry_inc;
                    end
                end
                CTRL_RUN: begin
                    if (!start_s) begin
                        state_next = CTRL_IDLE;
                        timer_next = '0;
                    end else if (!link_is_run) begin
                        state_next = CTRL_BACKOFF;
                        timer_next = BACKOFF_LOAD;
                        retry_next = retry_inc;
                    end
                end
                CTRL_BACKOFF: begin
                    timer_next = timer_dec;
                    if (!start_s) begin
                        state_next = CTRL_IDLE;
                        timer_next = '0;
                    end else if (timer_reg == '0) begin
                        if (retry_reg >= RETRY_LIMIT) begin
                            state_next = CTRL_FAIL;
                            timer_next = '0;
                        end else begin
                            state_next = CTRL_ARM;
                            timer_next = TIMEOUT_LOAD;
                        end
                    end
                end
                CTRL_FAIL: begin
                    if (!start_s) begin
                        state_next = CTRL_IDLE;
                    end
                end
                default: begin
                    state_next = CTRL_IDLE;
                    timer_next = '0;
                end
            endcase
        end
    end

    // Status word assembled from the state being entered.
    logic [7:0] status_next;

    always_comb begin
        status_next                          = '0;
        status_next[ST_CODE_MSB:ST_CODE_LSB] = state_next;
        status_next[ST_LINK_UP]              = (state_next == CTRL_RUN);
        status_next[ST_LINK_FAIL]            = (state_next == CTRL_FAIL);
    end

    // State, timer and retry registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= CTRL_IDLE;
            timer_reg <= '0;
            retry_reg <= '0;
        end else begin
            state_reg <= state_next;
            timer_reg <= timer_next;
            retry_reg <= retry_next;
        end
    end

    // ------------------------------------------------------------------
    // Registered outputs, decoded from the state being entered
    // ------------------------------------------------------------------
    logic       link_start_reg;
    logic       auto_start_reg;
    logic       link_disable_reg;
    logic       link_up_reg;
    logic       link_fail_reg;
    logic [7:0] status_reg;

    // Output registers so the link FSM and PIO see glitch-free levels.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            link_start_reg   <= 1'b0;
            auto_start_reg   <= 1'b0;
            link_disable_reg <= 1'b0;
            link_up_reg      <= 1'b0;
            link_fail_reg    <= 1'b0;
            status_reg       <= '0;
        end else begin
            link_start_reg   <= (state_next == CTRL_ARM) ||
                                (state_next == CTRL_WAIT_RUN) ||
                                (state_next == CTRL_RUN);
            auto_start_reg   <= auto_s && !disable_s && (state_next != CTRL_FAIL);
            link_disable_reg <= disable_s;
            link_up_reg      <= (state_next == CTRL_RUN);
            link_fail_reg    <= (state_next == CTRL_FAIL);
            status_reg       <= status_next;
        end
    end

    assign link_start   = link_start_reg;
    assign auto_start   = auto_start_reg;
    assign link_disable = link_disable_reg;
    assign link_up      = link_up_reg;
    assign link_fail    = link_fail_reg;
    assign retry_count  = retry_reg;
    assign status       = status_reg;

endmodule

// File: doc/spw_link_start_ctrl.md
Name: spw_link_start_ctrl

Overview:
- Sits between the Avalon PIO command bits (link_start / auto_start / link_disable) and the SpaceWire uLight link interface FSM.
- Turns the PIO command levels into the control signals the link FSM expects.
- Supervises connection attempts with a timeout, a backoff period and a bounded retry count.
- Produces an 8-bit status word for a status PIO, so software sees link up / link failed without polling the core directly.

Parameters:
- SYNC_STAGES, 2, number of synchronizer flops on each PIO command input (minimum 2).
- CNT_W, 16, width of the shared timeout/backoff down-counter.
- TIMEOUT_CYCLES, 5000, cycles allowed from link_start assertion to link_state==RUN.
- BACKOFF_CYCLES, 2500, cycles link_start is held low between attempts.
- MAX_RETRY, 15, failed attempts before entering FAIL (4-bit value).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- start_req  in  1  PIO link-start command level (asynchronous to clk).
- auto_req  in  1  PIO auto-start command level (asynchronous).
- disable_req  in  1  PIO link-disable command level (asynchronous).
- link_state  in  3  SpW FSM state: 0 ErrorReset, 1 ErrorWait, 2 Ready, 3 Started, 4 Connecting, 5 Run; 6 and 7 are treated as ErrorReset.
- link_start  out  1  to SpW FSM.
- auto_start  out  1  to SpW FSM.
- link_disable  out  1  to SpW FSM.
- link_up  out  1  high while in RUN.
- link_fail  out  1  high while in FAIL.
- retry_count  out  4  failed attempts since the last IDLE exit; saturates at MAX_RETRY.
- status  out  8  status[2:0] = ctrl state code, [3] = link_up, [4] = link_fail, [7:5] = 0.

Behaviour:
- Reset:
  - All outputs 0, state IDLE, timer 0, retry_count 0.
  - Synchronizer flops reset to 0.
- Synchronization:
  - start_s / auto_s / disable_s are the inputs after SYNC_STAGES flops.
  - An input change reaches the FSM decision after SYNC_STAGES cycles; registered outputs change one cycle later.
  - start_req already high when reset is released is legal and starts an attempt.
- All outputs are registered. Ctrl state codes: IDLE=0, ARM=1, WAIT_RUN=2, RUN=3, BACKOFF=4, FAIL=5.
- Priority: disable_s overrides everything.
  - From any state: go to IDLE, link_disable=1, link_start=0, auto_start=0, retry_count cleared.
  - link_disable follows disable_s in every state.
- IDLE: link_start=0. If start_s=1 and disable_s=0: go to ARM, retry_count=0.
- ARM (one cycle): load timer=TIMEOUT_CYCLES-1, set link_start=1, go to WAIT_RUN.
- WAIT_RUN: link_start=1, timer decrements each cycle. Checked in this order:
  - start_s=0 -> IDLE.
  - link_state==5 -> RUN.
  - timer==0 -> BACKOFF, retry_count+1 (saturating).
  - If link_state==5 and timer==0 occur in the same cycle, RUN wins.
- RUN: link_up=1, link_start=1.
  - start_s=0 -> IDLE.
  - link_state!=5 (link lost) -> BACKOFF, retry_count+1.
- BACKOFF:
  - On entry load timer=BACKOFF_CYCLES-1; link_start=0.
  - On timer==0: if retry_count>=MAX_RETRY -> FAIL, else -> ARM.
  - start_s=0 -> IDLE.
- FAIL: link_fail=1, link_start=0, auto_start=0. Leaves only when start_s=0 (-> IDLE) or disable_s=1.
- auto_start equals registered auto_s, except it is forced 0 in FAIL and whenever disable_s=1.
- Timer:
  - Unsigned CNT_W bits, never wraps below 0.
  - Parameter values exceeding 2^CNT_W are a configuration error; flag with an elaboration-time check.
- Reset asserted mid-attempt: immediate asynchronous return to reset values. No pulse stretching.

Decomposition:
- Package spw_link_pkg holds:
  - ctrl state enum (3-bit codes above);
  - link_state encoding constants (LS_ERROR_RESET..LS_RUN);
  - status bit-index constants.
- One sub-module, spw_sync_bit: SYNC_STAGES-deep reset-to-0 synchronizer, instantiated three times.

Test Plan:
Test parameters: TIMEOUT_CYCLES=20, BACKOFF_CYCLES=10, MAX_RETRY=3, SYNC_STAGES=2.
- Basic connect: release reset with start_req=1, link_state=5 applied at cycle 8 -> link_start=1 by cycle 4, link_up=1 one cycle after state 5 is seen, retry_count=0, status=8'h0B.
- Timeout and retry: start_req=1, link_state held at 2 -> link_start high 20 cycles, low 10, high again; retry_count 1, 2, 3; then FAIL with link_fail=1, status=8'h15, link_start stays 0.
- Link loss: in RUN, drop link_state to 0 -> link_up=0, state BACKOFF, retry_count=1; restore link_state=5 after re-arm -> RUN.
- Disable priority: in WAIT_RUN, assert disable_req -> within 3 cycles link_disable=1, link_start=0, auto_start=0, state IDLE, retry_count=0; release -> re-arm since start_req is still 1.
- Simultaneous: link_state becomes 5 on the cycle the timer reaches 0 -> RUN, retry_count unchanged.
- FAIL exit: in FAIL, drop start_req then raise it again -> IDLE then ARM, retry_count cleared, link_fail=0.
